// File: rtl/gate_mon_pkg.sv
// gate_mon_pkg: read-FSM state encoding and default widths shared by the activity monitor
package gate_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, LATCH = 2'b01, ACK = 2'b10} rd_state_t;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/activity_channel.sv
// activity_channel: synchronizes one probe, detects rising edges, counts them with saturation
module activity_channel
  import gate_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             CLR,
  input  logic             probe,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  logic [SYNC_STAGES-1:0] s;
  logic prev;
  logic inc;
  assign inc = ENB & s[SYNC_STAGES-1] & ~prev & ~&count;
  // prev follows the synchronizer even while disabled, so re-enabling never fakes an edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s <= '0;
      prev <= 1'b0;
      count <= '0;
      sat <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], probe};
      prev <= s[SYNC_STAGES-1];
      count <= CLR ? '0 : count + CNT_W'(inc);
      sat <= ~CLR & (sat | (inc & (count == ~CNT_W'(1))));
    end
  end
endmodule

// File: rtl/gate_activity_monitor.sv
// gate_activity_monitor: per-gate rising-edge counters with a request/acknowledge readout port
module gate_activity_monitor
  import gate_mon_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic             CLR,
  input  logic [N_CH-1:0]  PROBE,
  input  logic             RD_REQ,
  input  logic [SEL_W-1:0] RD_SEL,
  output logic             RD_ACK,
  output logic [CNT_W-1:0] RD_DATA,
  output logic [N_CH-1:0]  SAT,
  output logic             ANY_SAT
);
  rd_state_t state, nxt;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] mux;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    activity_channel #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .CLR(CLR), .probe(PROBE[i]),
      .count(cnt[i]), .sat(SAT[i])
    );
  end
  // out-of-range selects fall through to zero
  always_comb begin
    mux = '0;
    for (int i = 0; i < N_CH; i++) mux = (sel_q == SEL_W'(i)) ? cnt[i] : mux;
  end
  always_comb begin
    nxt = IDLE;
    nxt = (state == IDLE && RD_REQ) ? LATCH : (state == LATCH) ? ACK : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      sel_q <= '0;
      RD_ACK <= 1'b0;
      RD_DATA <= '0;
      ANY_SAT <= 1'b0;
    end else begin
      state <= nxt;
      sel_q <= (state == IDLE && RD_REQ) ? RD_SEL : sel_q;
      RD_ACK <= (state == LATCH);
      RD_DATA <= (state == LATCH) ? mux : RD_DATA;
      ANY_SAT <= |SAT;
    end
  end
endmodule

// File: tb/tb_gate_activity_monitor.sv
// tb_gate_activity_monitor: directed and random stimulus against a level-history reference model
module tb_gate_activity_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1, enb = 1'b0, clr = 1'b0, rd_req = 1'b0;
  logic [3:0] probe = '0;
  logic [1:0] rd_sel = '0;
  logic rd_ack, any_sat, rd_ack3, any_sat3;
  logic [3:0] rd_data, sat, rd_data3;
  logic [2:0] sat3;
  int n_vec = 0, n_cmp = 0, errs = 0;
  int m_cnt [4];
  logic [3:0] m_sat, p1, p2, p3;
  logic m_any, m_any3, m_ack;
  int m_data, m_data3, busy, sel;

  always #5 clk = ~clk;

  gate_activity_monitor #(.N_CH(4), .CNT_W(4), .SYNC_STAGES(2), .SEL_W(2)) dut (
    .CLK(clk), .RESET(reset), .ENB(enb), .CLR(clr), .PROBE(probe), .RD_REQ(rd_req),
    .RD_SEL(rd_sel), .RD_ACK(rd_ack), .RD_DATA(rd_data), .SAT(sat), .ANY_SAT(any_sat)
  );
  gate_activity_monitor #(.N_CH(3), .CNT_W(4), .SYNC_STAGES(2), .SEL_W(2)) dut3 (
    .CLK(clk), .RESET(reset), .ENB(enb), .CLR(clr), .PROBE(probe[2:0]), .RD_REQ(rd_req),
    .RD_SEL(rd_sel), .RD_ACK(rd_ack3), .RD_DATA(rd_data3), .SAT(sat3), .ANY_SAT(any_sat3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A probe level sampled at edge n-2 that was low at n-3 is a synchronized rising edge at n.
  task automatic tick();
    logic [3:0] e, old_sat;
    @(posedge clk);
    n_vec++;
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_sat = '0; m_any = 0; m_any3 = 0; m_ack = 0;
      m_data = 0; m_data3 = 0; busy = 0; sel = 0;
      p1 = '0; p2 = '0; p3 = '0;
    end else begin
      e = p2 & ~p3;
      old_sat = m_sat;
      m_any = |old_sat;
      m_any3 = |old_sat[2:0];
      if (busy == 2) begin
        m_data = (sel < 4) ? m_cnt[sel] : 0;
        m_data3 = (sel < 3) ? m_cnt[sel] : 0;
        m_ack = 1; busy = 1;
      end else if (busy == 1) begin
        m_ack = 0; busy = 0;
      end else if (rd_req) begin
        sel = int'(rd_sel); busy = 2;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          m_cnt[i] = 0; m_sat[i] = 0;
        end else if (enb && e[i] && m_cnt[i] < 15) begin
          m_cnt[i]++;
          if (m_cnt[i] == 15) m_sat[i] = 1;
        end
      end
      p3 = p2; p2 = p1; p1 = probe;
    end
    #1;
    chk("ack", rd_ack, m_ack);
    chk("data", rd_data, m_data);
    chk("sat", sat, m_sat);
    chk("any_sat", any_sat, m_any);
    chk("ack3", rd_ack3, m_ack);
    chk("data3", rd_data3, m_data3);
    chk("sat3", sat3, m_sat[2:0]);
    chk("any_sat3", any_sat3, m_any3);
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    probe[ch] = 1'b1;
    repeat (hi) tick();
    probe[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_read(input int s, output logic [3:0] d, output logic [3:0] d3,
                         output logic a, output logic a3);
    rd_req = 1'b1; rd_sel = 2'(s);
    tick();
    rd_req = 1'b0;
    tick();
    d = rd_data; d3 = rd_data3; a = rd_ack; a3 = rd_ack3;
    tick();
  endtask

  initial begin
    logic [3:0] d, d3;
    logic a, a3;
    repeat (2) tick();
    reset = 1'b0; enb = 1'b1;
    repeat (2) tick();
    repeat (3) pulse(0, 4, 4);
    do_read(0, d, d3, a, a3);
    chk("rd_ch0", d, 3); chk("rd_ch0_ack", a, 1);
    enb = 1'b0;
    repeat (5) pulse(1, 4, 4);
    enb = 1'b1;
    repeat (2) pulse(1, 4, 4);
    do_read(1, d, d3, a, a3);
    chk("rd_ch1_enb", d, 2);
    repeat (17) pulse(2, 2, 2);
    tick();
    chk("sat_ch2", sat, 4'b0100);
    do_read(2, d, d3, a, a3);
    chk("rd_ch2_sat", d, 15); chk("any_sat_set", any_sat, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("sat_clr", sat, 0);
    do_read(2, d, d3, a, a3);
    chk("rd_ch2_clr", d, 0);
    probe[3] = 1'b1; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    probe[3] = 1'b0; repeat (3) tick();
    do_read(3, d, d3, a, a3);
    chk("rd_ch3_clr_edge", d, 0);
    pulse(1, 3, 3);
    probe[1] = 1'b1; tick();
    rd_req = 1'b1; rd_sel = 2'd1; tick(); tick();
    chk("race_ack", rd_ack, 1); chk("race_old", rd_data, 1);
    tick(); rd_req = 1'b0;
    chk("held_req_ack0", rd_ack, 0);
    tick();
    chk("held_req_ack1", rd_ack, 0);
    probe[1] = 1'b0;
    do_read(1, d, d3, a, a3);
    chk("race_new", d, 2);
    rd_req = 1'b1; rd_sel = 2'd0; tick();
    rd_req = 1'b0; reset = 1'b1; tick();
    chk("abort_ack", rd_ack, 0);
    reset = 1'b0; tick();
    chk("abort_ack2", rd_ack, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(i, d, d3, a, a3);
      chk("post_reset_cnt", d, 0);
    end
    pulse(0, 2, 3);
    do_read(3, d, d3, a, a3);
    chk("sel_oob_data", d3, 0); chk("sel_oob_ack", a3, 1);
    for (int c = 0; c < 800; c++) begin
      probe = probe ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      enb = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 249) == 0);
      rd_req = ($urandom_range(0, 2) == 0);
      rd_sel = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; clr = 1'b0; rd_req = 1'b0;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end
endmodule
